// File: rtl/inst_serializer.sv
// Instruction byte-stream encoder: sends opc, then opl bytes little-endian (8 long / 5 short by opc[0]).
// Define ISER_CSUM_EN to append an XOR checksum byte to every frame.
module inst_serializer #(
  parameter int LONG_BYTES  = 8,
  parameter int SHORT_BYTES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  opc,
  input  logic [63:0] opl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);

`ifdef ISER_CSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, OPC = 2'd1, OPL = 2'd2, CSUM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, OPC = 2'd1, OPL = 2'd2} state_t;
`endif

  localparam logic [2:0] LONG_LAST  = 3'(LONG_BYTES - 1);
  localparam logic [2:0] SHORT_LAST = 3'(SHORT_BYTES - 1);

  state_t      state_r;
  state_t      state_next_s;
  logic [2:0]  idx_r;
  logic [2:0]  idx_next_s;
  logic [7:0]  opc_r;
  logic [63:0] opl_r;
  logic [7:0]  opl_byte_s;
  logic [2:0]  last_idx_s;
  logic        op_last_s;
  logic        accept_s;
  logic        xfer_s;
`ifdef ISER_CSUM_EN
  logic [7:0]  csum_r;
`endif

  assign opl_byte_s = opl_r[{idx_r, 3'b000} +: 8];
  assign last_idx_s = opc_r[0] ? SHORT_LAST : LONG_LAST;
  assign op_last_s  = (idx_r == last_idx_s);
  assign xfer_s     = out_valid & out_ready;
  // The next instruction may be taken in the same cycle the previous frame's last byte leaves.
  assign in_ready   = (state_r == IDLE) | (xfer_s & out_last);
  assign accept_s   = in_valid & in_ready;
  assign busy       = (state_r != IDLE);

  // Output decode from registered state only, so in_ready has no path back into it.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state_r)
      IDLE: begin
        out_valid = 1'b0;
      end
      OPC: begin
        out_valid = 1'b1;
        out_data  = opc_r;
      end
      OPL: begin
        out_valid = 1'b1;
        out_data  = opl_byte_s;
`ifdef ISER_CSUM_EN
        out_last  = 1'b0;
`else
        out_last  = op_last_s;
`endif
      end
`ifdef ISER_CSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_r;
        out_last  = 1'b1;
      end
`endif
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // Next-state and byte-index logic.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = OPC;
        end else begin
          state_next_s = IDLE;
        end
      end
      OPC: begin
        if (out_ready) begin
          state_next_s = OPL;
          idx_next_s   = 3'd0;
        end else begin
          state_next_s = OPC;
        end
      end
      OPL: begin
        if (out_ready) begin
          if (op_last_s) begin
            idx_next_s = 3'd0;
`ifdef ISER_CSUM_EN
            state_next_s = CSUM;
`else
            state_next_s = accept_s ? OPC : IDLE;
`endif
          end else begin
            idx_next_s = idx_r + 3'd1;
          end
        end else begin
          state_next_s = OPL;
        end
      end
`ifdef ISER_CSUM_EN
      CSUM: begin
        if (out_ready) begin
          state_next_s = accept_s ? OPC : IDLE;
        end else begin
          state_next_s = CSUM;
        end
      end
`endif
      default: begin
        state_next_s = IDLE;
        idx_next_s   = 3'd0;
      end
    endcase
  end

  // State, index and holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      opc_r   <= 8'h00;
      opl_r   <= 64'h0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      if (accept_s) begin
        opc_r <= opc;
        opl_r <= opl;
      end
    end
  end

`ifdef ISER_CSUM_EN
  // Running XOR of opc and every operand byte actually sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_r <= 8'h00;
    end else if (accept_s) begin
      csum_r <= opc;
    end else if ((state_r == OPL) && xfer_s) begin
      csum_r <= csum_r ^ opl_byte_s;
    end
  end
`endif

endmodule

// File: tb/tb_inst_serializer.sv
// Self-checking bench for inst_serializer: directed cases plus random frames against a byte-queue model.
module tb_inst_serializer;
  localparam int LONG  = 8;
  localparam int SHORT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  opc;
  logic [63:0] opl;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  typedef struct packed {
    logic [7:0]  o;
    logic [63:0] l;
  } instr_t;

  logic [7:0] exp_q[$];
  instr_t     instr_q[$];
  int errors = 0;
  int checks = 0;
  int gaps;
  int busy_cycles;
  int frame_len;

  inst_serializer #(.LONG_BYTES(LONG), .SHORT_BYTES(SHORT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opc(opc), .opl(opl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the byte sequence a frame must produce.
  task automatic model(input logic [7:0] o, input logic [63:0] l);
    int n;
    logic [7:0] b;
    logic [7:0] x;
    n = o[0] ? SHORT : LONG;
    exp_q.push_back(o);
    x = o;
    for (int i = 0; i < n; i++) begin
      b = 8'((l >> (8 * i)) & 64'hFF);
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef ISER_CSUM_EN
    exp_q.push_back(x);
    frame_len = n + 2;
`else
    frame_len = n + 1;
`endif
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready.
  task automatic run(input int mode, input int stop_after, input int budget);
    int cyc = 0;
    int cnt = 0;
    bit started = 1'b0;
    gaps = 0;
    busy_cycles = 0;
    while ((instr_q.size() != 0 || exp_q.size() != 0) && cnt < stop_after && cyc < budget) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (instr_q.size() != 0) begin
        in_valid = 1'b1;
        opc = instr_q[0].o;
        opl = instr_q[0].l;
      end else begin
        in_valid = 1'b0;
        opc = 8'($urandom);
        opl = {$urandom, $urandom};
      end
      #1;
      if (busy) busy_cycles++;
      if (out_valid) begin
        started = 1'b1;
        if (exp_q.size() == 0) begin
          check("spurious_valid", out_valid, 1'b0);
        end else begin
          check("out_data", out_data, exp_q[0]);
          check("out_last", out_last, exp_q.size() == 1);
          if (out_ready) begin
            check("in_ready_xfer", in_ready, exp_q.size() == 1);
            void'(exp_q.pop_front());
            cnt++;
          end else begin
            check("in_ready_stall", in_ready, 1'b0);
          end
        end
      end else begin
        if (started && exp_q.size() != 0) gaps++;
        check("idle_in_ready", in_ready, 1'b1);
      end
      if (in_valid && in_ready) begin
        model(instr_q[0].o, instr_q[0].l);
        void'(instr_q.pop_front());
      end
      cyc++;
    end
    if (cnt < stop_after) check("drain", exp_q.size() + instr_q.size(), 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    opc = 8'h00;
    opl = 64'h0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1: long form, always ready
    instr_q.push_back('{8'h10, 64'h0123_4567_89AB_CDEF});
    run(0, 1000, 100);
    check("long_busy_cycles", busy_cycles, frame_len);
    check("long_gaps", gaps, 0);

    // 2: short form
    instr_q.push_back('{8'h11, 64'h0123_4567_89AB_CDEF});
    run(0, 1000, 100);
    check("short_busy_cycles", busy_cycles, frame_len);

    // 3: backpressure 1,0,0,...
    instr_q.push_back('{8'h10, 64'h0123_4567_89AB_CDEF});
    run(1, 1000, 200);

    // 4: back-to-back long then short
    instr_q.push_back('{8'h10, 64'h0123_4567_89AB_CDEF});
    instr_q.push_back('{8'h11, 64'h0123_4567_89AB_CDEF});
    run(0, 1000, 100);
    check("b2b_gaps", gaps, 0);

    // 5: reset after 3 bytes
    instr_q.push_back('{8'h10, 64'h0123_4567_89AB_CDEF});
    run(0, 3, 100);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    instr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    instr_q.push_back('{8'h04, {$urandom, $urandom}});
    run(0, 1000, 100);

    // 6: checksum example (checksum byte appears only when enabled)
    instr_q.push_back('{8'h11, 64'h0000_0001_0203_0405});
    run(0, 1000, 100);

    // random frames, random backpressure, queued back-to-back
    for (int k = 0; k < 12; k++) begin
      instr_q.push_back('{8'($urandom), {$urandom, $urandom}});
    end
    run(2, 10000, 2000);
    for (int k = 0; k < 6; k++) begin
      instr_q.push_back('{8'($urandom), {$urandom, $urandom}});
    end
    run(0, 10000, 500);
    check("rand_b2b_gaps", gaps, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
